// File: rtl/vram_arbiter_pkg.sv
// rtl/vram_arbiter_pkg.sv - shared types and helpers for the video RAM arbiter
package vram_arbiter_pkg;

    // Owner of the RAM access issued in a given cycle; registered to route read returns.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_L    = 2'd1,
        OWN_S    = 2'd2,
        OWN_CPU  = 2'd3
    } owner_e;

    localparam int WAIT_W   = 4;
    localparam int WORD_AW  = 15;
    localparam int CPU_AW   = 17;

    // One-hot byte write enable for a byte lane within a 32-bit word.
    function automatic logic [3:0] lane_bytesel(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/vram_cpu_lane.sv
// rtl/vram_cpu_lane.sv - CPU byte-lane steering onto the 32-bit video RAM word
module vram_cpu_lane
    import vram_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        grant,
    input  logic [1:0]  lane,
    input  logic        cpu_write,
    input  logic [7:0]  cpu_wrdata,
    input  logic [31:0] ram_rddata,
    output logic [31:0] wrdata,
    output logic [3:0]  bytesel,
    output logic [7:0]  rddata
);

    logic [1:0] lane_q;
    logic [1:0] lane_d;

    // Write data and byte enables only leave this block while the CPU owns the bus.
    always_comb begin
        wrdata  = 32'd0;
        bytesel = 4'd0;
        if (grant) begin
            wrdata = {4{cpu_wrdata}};
            if (cpu_write) begin
                bytesel = lane_bytesel(lane);
            end
        end
    end

    // Capture the lane at grant so the read byte can be picked from next cycle's RAM word.
    always_comb begin
        lane_d = lane_q;
        if (rst) begin
            lane_d = 2'd0;
        end else if (grant) begin
            lane_d = lane;
        end
    end

    // Lane register.
    always_ff @(posedge clk) begin
        lane_q <= lane_d;
    end

    // Extract the addressed byte from the returned RAM word.
    always_comb begin
        rddata = 8'd0;
        case (lane_q)
            2'd0:    rddata = ram_rddata[7:0];
            2'd1:    rddata = ram_rddata[15:8];
            2'd2:    rddata = ram_rddata[23:16];
            default: rddata = ram_rddata[31:24];
        endcase
    end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - fixed-priority layer/sprite/CPU arbiter in front of video RAM
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int unsigned CPU_MAX_WAIT = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                l_req,
    input  logic [WORD_AW-1:0]  l_addr,
    output logic                l_ack,
    output logic [31:0]         l_rddata,
    output logic                l_rddata_valid,
    input  logic                s_req,
    input  logic [WORD_AW-1:0]  s_addr,
    output logic                s_ack,
    output logic [31:0]         s_rddata,
    output logic                s_rddata_valid,
    input  logic                cpu_req,
    input  logic [CPU_AW-1:0]   cpu_addr,
    input  logic                cpu_write,
    input  logic [7:0]          cpu_wrdata,
    output logic                cpu_ack,
    output logic [7:0]          cpu_rddata,
    output logic                cpu_rddata_valid,
    output logic [WORD_AW-1:0]  ram_addr,
    output logic [31:0]         ram_wrdata,
    output logic [3:0]          ram_wrbytesel,
    output logic                ram_write,
    input  logic [31:0]         ram_rddata
);

    localparam logic [WAIT_W-1:0] MAX_WAIT = WAIT_W'(CPU_MAX_WAIT);

    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;
    owner_e            owner_q;
    owner_e            owner_d;
    owner_e            grant_own;
    logic              cpu_force;
    logic [31:0]       lane_wrdata;
    logic [3:0]        lane_bytesel_w;

    assign cpu_force = cpu_req && (wait_q == MAX_WAIT);

    // One grant per cycle: aged CPU first, then layer > sprite > cpu; nothing while in reset.
    always_comb begin
        grant_own = OWN_NONE;
        if (!rst) begin
            if (cpu_force) begin
                grant_own = OWN_CPU;
            end else if (l_req) begin
                grant_own = OWN_L;
            end else if (s_req) begin
                grant_own = OWN_S;
            end else if (cpu_req) begin
                grant_own = OWN_CPU;
            end
        end
    end

    assign l_ack   = (grant_own == OWN_L);
    assign s_ack   = (grant_own == OWN_S);
    assign cpu_ack = (grant_own == OWN_CPU);

    vram_cpu_lane u_cpu_lane (
        .clk        (clk),
        .rst        (rst),
        .grant      (cpu_ack),
        .lane       (cpu_addr[1:0]),
        .cpu_write  (cpu_write),
        .cpu_wrdata (cpu_wrdata),
        .ram_rddata (ram_rddata),
        .wrdata     (lane_wrdata),
        .bytesel    (lane_bytesel_w),
        .rddata     (cpu_rddata)
    );

    // Drive the RAM bus from whichever requester holds the grant; idle bus is all zero.
    always_comb begin
        ram_addr      = '0;
        ram_wrdata    = 32'd0;
        ram_wrbytesel = 4'd0;
        ram_write     = 1'b0;
        case (grant_own)
            OWN_L:   ram_addr = l_addr;
            OWN_S:   ram_addr = s_addr;
            OWN_CPU: begin
                ram_addr      = cpu_addr[CPU_AW-1:2];
                ram_wrdata    = lane_wrdata;
                ram_wrbytesel = lane_bytesel_w;
                ram_write     = cpu_write;
            end
            default: ;
        endcase
    end

    // Aging counter: counts lost CPU cycles, saturates, clears on grant or withdrawn request.
    always_comb begin
        wait_d = wait_q;
        if (rst || !cpu_req || cpu_ack) begin
            wait_d = '0;
        end else if (wait_q < MAX_WAIT) begin
            wait_d = wait_q + 1'b1;
        end
    end

    // Remember who is owed read data next cycle; CPU writes return nothing.
    always_comb begin
        owner_d = grant_own;
        if (rst || (cpu_ack && cpu_write)) begin
            owner_d = OWN_NONE;
        end
    end

    // Counter and owner registers.
    always_ff @(posedge clk) begin
        wait_q  <= wait_d;
        owner_q <= owner_d;
    end

    // Read return: pass-through data, valid for the registered owner; suppressed during reset.
    assign l_rddata         = ram_rddata;
    assign s_rddata         = ram_rddata;
    assign l_rddata_valid   = !rst && (owner_q == OWN_L);
    assign s_rddata_valid   = !rst && (owner_q == OWN_S);
    assign cpu_rddata_valid = !rst && (owner_q == OWN_CPU);

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed self-checking bench for vram_arbiter
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        l_req, s_req, cpu_req, cpu_write;
    logic [14:0] l_addr, s_addr;
    logic [16:0] cpu_addr;
    logic [7:0]  cpu_wrdata;
    logic        l_ack, s_ack, cpu_ack;
    logic [31:0] l_rddata, s_rddata;
    logic [7:0]  cpu_rddata;
    logic        l_rddata_valid, s_rddata_valid, cpu_rddata_valid;
    logic [14:0] ram_addr;
    logic [31:0] ram_wrdata;
    logic [3:0]  ram_wrbytesel;
    logic        ram_write;
    logic [31:0] ram_rddata;

    logic [31:0] mem [0:32767];
    logic        pl_we = 1'b0;
    logic [14:0] pl_addr = '0;
    logic [31:0] pl_data = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vram_arbiter #(.CPU_MAX_WAIT(8)) dut (
        .clk(clk), .rst(rst),
        .l_req(l_req), .l_addr(l_addr), .l_ack(l_ack),
        .l_rddata(l_rddata), .l_rddata_valid(l_rddata_valid),
        .s_req(s_req), .s_addr(s_addr), .s_ack(s_ack),
        .s_rddata(s_rddata), .s_rddata_valid(s_rddata_valid),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_write(cpu_write),
        .cpu_wrdata(cpu_wrdata), .cpu_ack(cpu_ack),
        .cpu_rddata(cpu_rddata), .cpu_rddata_valid(cpu_rddata_valid),
        .ram_addr(ram_addr), .ram_wrdata(ram_wrdata),
        .ram_wrbytesel(ram_wrbytesel), .ram_write(ram_write),
        .ram_rddata(ram_rddata)
    );

    // Behavioural video RAM: byte-enabled write, 1-cycle registered read, bench preload port.
    always @(posedge clk) begin
        if (pl_we) begin
            mem[pl_addr] <= pl_data;
        end else if (ram_write) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_wrbytesel[b]) mem[ram_addr][b*8 +: 8] <= ram_wrdata[b*8 +: 8];
            end
        end
        ram_rddata <= mem[ram_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [14:0] a, input logic [31:0] d);
        pl_addr = a;
        pl_data = d;
        pl_we   = 1'b1;
        tick();
        pl_we   = 1'b0;
    endtask

    function automatic logic [2:0] valids();
        return {l_rddata_valid, s_rddata_valid, cpu_rddata_valid};
    endfunction

    function automatic logic [2:0] acks();
        return {l_ack, s_ack, cpu_ack};
    endfunction

    initial begin
        rst = 1'b1;
        l_req = 0; s_req = 0; cpu_req = 0; cpu_write = 0;
        l_addr = '0; s_addr = '0; cpu_addr = '0; cpu_wrdata = '0;
        preload(15'h1000, 32'h12345678);
        preload(15'h0001, 32'h00000000);
        preload(15'h0010, 32'hAAAA0001);
        preload(15'h0020, 32'hBBBB0002);
        preload(15'h0030, 32'hCC334455);
        preload(15'h0002, 32'h11223344);

        // Requests during reset get no grant and no write.
        l_req = 1; cpu_req = 1; cpu_write = 1; cpu_addr = 17'h4; cpu_wrdata = 8'h77;
        #1;
        check_eq("rst_acks", 32'(acks()), 32'h0);
        check_eq("rst_ram_write", 32'(ram_write), 32'h0);
        check_eq("rst_valids", 32'(valids()), 32'h0);
        tick();
        l_req = 0; cpu_req = 0; cpu_write = 0;
        rst = 1'b0;

        // 1. idle after reset.
        for (int i = 0; i < 10; i++) begin
            #1;
            check_eq("idle_write", 32'(ram_write), 32'h0);
            check_eq("idle_addr", 32'(ram_addr), 32'h0);
            check_eq("idle_valids", 32'(valids()), 32'h0);
            tick();
        end

        // 2. layer read.
        l_req = 1; l_addr = 15'h1000;
        #1;
        check_eq("l_ack", 32'(acks()), 32'h4);
        check_eq("l_ram_addr", 32'(ram_addr), 32'h1000);
        tick();
        l_req = 0;
        #1;
        check_eq("l_valids", 32'(valids()), 32'h4);
        check_eq("l_rddata", l_rddata, 32'h12345678);

        // 3. CPU byte write then read back.
        tick();
        cpu_req = 1; cpu_write = 1; cpu_addr = 17'h00006; cpu_wrdata = 8'hA5;
        #1;
        check_eq("cw_ack", 32'(acks()), 32'h1);
        check_eq("cw_addr", 32'(ram_addr), 32'h1);
        check_eq("cw_bytesel", 32'(ram_wrbytesel), 32'h4);
        check_eq("cw_wrdata", ram_wrdata, 32'hA5A5A5A5);
        check_eq("cw_write", 32'(ram_write), 32'h1);
        tick();
        cpu_write = 0;
        #1;
        check_eq("cw_no_valid", 32'(valids()), 32'h0);
        check_eq("cr_bytesel", 32'(ram_wrbytesel), 32'h0);
        check_eq("cr_write", 32'(ram_write), 32'h0);
        tick();
        cpu_req = 0;
        #1;
        check_eq("cr_valids", 32'(valids()), 32'h1);
        check_eq("cr_rddata", 32'(cpu_rddata), 32'hA5);
        tick();

        // 4. all three at once: layer, sprite, cpu in order.
        l_req = 1; l_addr = 15'h10; s_req = 1; s_addr = 15'h20;
        cpu_req = 1; cpu_addr = 17'h000C3;
        #1;
        check_eq("p0_acks", 32'(acks()), 32'h4);
        check_eq("p0_addr", 32'(ram_addr), 32'h10);
        tick();
        l_req = 0;
        #1;
        check_eq("p1_valids", 32'(valids()), 32'h4);
        check_eq("p1_lrd", l_rddata, 32'hAAAA0001);
        check_eq("p1_acks", 32'(acks()), 32'h2);
        check_eq("p1_addr", 32'(ram_addr), 32'h20);
        tick();
        s_req = 0;
        #1;
        check_eq("p2_valids", 32'(valids()), 32'h2);
        check_eq("p2_srd", s_rddata, 32'hBBBB0002);
        check_eq("p2_acks", 32'(acks()), 32'h1);
        check_eq("p2_addr", 32'(ram_addr), 32'h30);
        tick();
        cpu_req = 0;
        #1;
        check_eq("p3_valids", 32'(valids()), 32'h1);
        check_eq("p3_cpurd", 32'(cpu_rddata), 32'hCC);
        tick();

        // 5. aging: CPU wins after exactly 8 lost cycles, twice in a row.
        l_req = 1; l_addr = 15'h10; cpu_req = 1; cpu_addr = 17'h0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++) begin
                #1;
                check_eq($sformatf("age%0d_lose%0d", r, i), 32'(acks()), 32'h4);
                tick();
            end
            #1;
            check_eq($sformatf("age%0d_win", r), 32'(acks()), 32'h1);
            tick();
            #1;
            check_eq($sformatf("age%0d_valid", r), 32'(valids()), 32'h1);
        end
        l_req = 0; cpu_req = 0;
        tick();

        // 6a. reset the cycle after a sprite ack: no valid pulse.
        s_req = 1; s_addr = 15'h5;
        #1;
        check_eq("s6_ack", 32'(acks()), 32'h2);
        tick();
        s_req = 0; rst = 1;
        #1;
        check_eq("s6_valid_rst", 32'(valids()), 32'h0);
        tick();
        rst = 0;
        #1;
        check_eq("s6_valid_after", 32'(valids()), 32'h0);
        tick();

        // 6b. CPU write presented during reset never reaches RAM.
        rst = 1; cpu_req = 1; cpu_write = 1; cpu_addr = 17'h00008; cpu_wrdata = 8'hFF;
        #1;
        check_eq("w6_write", 32'(ram_write), 32'h0);
        check_eq("w6_ack", 32'(acks()), 32'h0);
        tick();
        rst = 0; cpu_req = 0; cpu_write = 0;
        #1;
        check_eq("w6_mem", mem[2], 32'h11223344);
        cpu_req = 1;
        tick();
        cpu_req = 0;
        #1;
        check_eq("w6_readback", 32'(cpu_rddata), 32'h44);
        check_eq("w6_rb_valid", 32'(valids()), 32'h1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
